effects_dac_out: RTL and testbench

EFFECTS_DAC_OUT -- requirements
Module: effects_dac_out

---
 rtl/effects_pkg.sv | 8 +
 rtl/effects_dac_out_spi_dac_tx.sv | 57 +++++
 rtl/effects_dac_out.sv | 84 ++++++++
 tb/tb_effects_dac_out.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/effects_pkg.sv
// effects_pkg: shared encodings and constants for the effects DAC output path
package effects_pkg;
  typedef enum logic [2:0] {SEL_SIN, SEL_OD, SEL_DELAY, SEL_ECHO, SEL_REVERB, SEL_MUTE} sel_e;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
  localparam logic [11:0] MIDSCALE = 12'h800;
  localparam int FRAME_BITS = 16;
  localparam logic [3:0] VOL_UNITY = 4'd8;
endpackage

// File: rtl/effects_dac_out_spi_dac_tx.sv
// spi_dac_tx: 16-bit SPI frame serializer, SCLK idles high, data changes on rising edges
module spi_dac_tx
  import effects_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sync_n,
  output logic                  sclk,
  output logic                  din,
  output logic                  done
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] dcnt;
  logic [$clog2(2*FRAME_BITS)-1:0] hcnt;
  logic [FRAME_BITS-1:0] sr;
  logic active, half_end;
  assign half_end = active && dcnt == DW'(CLK_DIV-1);
  assign done = half_end && hcnt == '1;
  // first half-period stays high so the first toggle is a falling edge that samples the MSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_n <= 1'b1;
      sclk   <= 1'b1;
      din    <= 1'b0;
      sr     <= '0;
      dcnt   <= '0;
      hcnt   <= '0;
      active <= 1'b0;
    end else if (start && !active) begin
      sync_n <= 1'b0;
      sclk   <= 1'b1;
      din    <= frame[FRAME_BITS-1];
      sr     <= {frame[FRAME_BITS-2:0], 1'b0};
      dcnt   <= '0;
      hcnt   <= '0;
      active <= 1'b1;
    end else if (half_end) begin
      dcnt <= '0;
      hcnt <= hcnt + 1'b1;
      sclk <= ~sclk;
      if (!sclk) begin
        din <= sr[FRAME_BITS-1];
        sr  <= {sr[FRAME_BITS-2:0], 1'b0};
      end
      if (done) begin
        sync_n <= 1'b1;
        active <= 1'b0;
      end
    end else if (active) begin
      dcnt <= dcnt + 1'b1;
    end
  end
endmodule

// File: rtl/effects_dac_out.sv
// effects_dac_out: selects an effect stream, applies volume and ships one DAC frame per sample period
module effects_dac_out
  import effects_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] data_in_sin,
  input  logic [11:0] data_in_OD,
  input  logic [11:0] data_in_DELAY,
  input  logic [11:0] data_in_ECHO,
  input  logic [11:0] data_in_REVERB,
  input  logic [2:0]  effect_sel,
  input  logic [3:0]  volume,
  output logic        dac_sync_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        sample_tick,
  output logic        busy,
  output logic        overrun
);
  if (SAMPLE_DIV < 32*CLK_DIV + 4 || CLK_DIV < 1) begin : g_param_check
    $error("effects_dac_out: SAMPLE_DIV too small for one frame or CLK_DIV < 1");
  end
  localparam int CW = $clog2(SAMPLE_DIV);
  logic [CW-1:0] cnt;
  logic [11:0] x, x_sel, y;
  logic [3:0] v;
  logic signed [12:0] diff;
  logic signed [16:0] prod, sh;
  logic tx_done;
  state_e state;
  assign sample_tick = cnt == CW'(SAMPLE_DIV-1);
  always_comb begin
    x_sel = effect_sel == SEL_SIN    ? data_in_sin    :
            effect_sel == SEL_OD     ? data_in_OD     :
            effect_sel == SEL_DELAY  ? data_in_DELAY  :
            effect_sel == SEL_ECHO   ? data_in_ECHO   :
            effect_sel == SEL_REVERB ? data_in_REVERB : MIDSCALE;
    diff = $signed({1'b0, x}) - $signed({1'b0, MIDSCALE});
    prod = 17'(diff) * 17'($signed({1'b0, v}));
    sh   = prod >>> 3;
    y    = 12'(sh + $signed({5'b0, MIDSCALE}));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      x       <= MIDSCALE;
      v       <= '0;
    end else begin
      cnt <= sample_tick ? '0 : cnt + 1'b1;
      if (sample_tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_tick) begin
          x     <= x_sel;
          v     <= volume > VOL_UNITY ? VOL_UNITY : volume;
          busy  <= 1'b1;
          state <= LOAD;
        end
        LOAD:  state <= SHIFT;
        SHIFT: if (tx_done) state <= DONE;
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  spi_dac_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == LOAD),
    .frame ({4'b0000, y}),
    .sync_n(dac_sync_n),
    .sclk  (dac_sclk),
    .din   (dac_din),
    .done  (tx_done)
  );
endmodule

// File: tb/tb_effects_dac_out.sv
// tb_effects_dac_out: directed vector bench for effects_dac_out at the minimum legal sample period
module tb_effects_dac_out;
  logic clk = 1'b0;
  logic rst_n;
  logic [11:0] sin, od, dly, ech, rev;
  logic [2:0] sel;
  logic [3:0] vol;
  logic sync_n, sclk, din, tick, busy, overrun;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  effects_dac_out #(.CLK_DIV(4), .SAMPLE_DIV(132)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_sin(sin), .data_in_OD(od), .data_in_DELAY(dly), .data_in_ECHO(ech), .data_in_REVERB(rev),
    .effect_sel(sel), .volume(vol),
    .dac_sync_n(sync_n), .dac_sclk(sclk), .dac_din(din),
    .sample_tick(tick), .busy(busy), .overrun(overrun)
  );
  typedef struct {
    logic [2:0]  sel;
    logic [3:0]  vol;
    logic [11:0] sin, od, dly, ech, rev;
    logic [11:0] y;
  } vec_t;
  vec_t vecs[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_sync(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sync_n === lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  // records the bit present on each SCLK falling edge while sync_n is low
  task automatic capture(input int change_at, input logic [2:0] new_sel, output logic [15:0] f, output int low);
    bit ok;
    logic prev;
    f = 'x;
    low = 0;
    wait_sync(1'b1, ok);
    if (ok) wait_sync(1'b0, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL frame_start: sync_n never fell within 400 cycles");
      return;
    end
    chk("busy_in_frame", busy, 1);
    f = '0;
    prev = sclk;
    while (sync_n === 1'b0 && low < 400) begin
      low++;
      if (low == change_at) sel = new_sel;
      if (prev && !sclk) f = {f[14:0], din};
      prev = sclk;
      @(negedge clk);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [15:0] f;
    int low, n, rises;
    bit ok;
    logic prev;
    vecs[0]  = '{3'd0, 4'd8,  12'hABC, 12'h123, 12'h456, 12'h789, 12'hDEF, 12'hABC};
    vecs[1]  = '{3'd1, 4'd4,  12'hABC, 12'hFFF, 12'h456, 12'h789, 12'hDEF, 12'hBFF};
    vecs[2]  = '{3'd1, 4'd0,  12'hABC, 12'hFFF, 12'h456, 12'h789, 12'hDEF, 12'h800};
    vecs[3]  = '{3'd1, 4'd15, 12'hABC, 12'h000, 12'h456, 12'h789, 12'hDEF, 12'h000};
    vecs[4]  = '{3'd6, 4'd8,  12'hABC, 12'hFFF, 12'h456, 12'h789, 12'hDEF, 12'h800};
    vecs[5]  = '{3'd2, 4'd8,  12'hABC, 12'hFFF, 12'h123, 12'h789, 12'hDEF, 12'h123};
    vecs[6]  = '{3'd3, 4'd2,  12'hABC, 12'hFFF, 12'h456, 12'h400, 12'hDEF, 12'h700};
    vecs[7]  = '{3'd4, 4'd9,  12'hABC, 12'hFFF, 12'h456, 12'h789, 12'h7FF, 12'h7FF};
    vecs[8]  = '{3'd4, 4'd1,  12'hABC, 12'hFFF, 12'h456, 12'h789, 12'h000, 12'h700};
    vecs[9]  = '{3'd0, 4'd3,  12'h801, 12'hFFF, 12'h456, 12'h789, 12'hDEF, 12'h800};
    vecs[10] = '{3'd1, 4'd7,  12'hABC, 12'h7FF, 12'h456, 12'h789, 12'hDEF, 12'h7FF};
    vecs[11] = '{3'd5, 4'd8,  12'hABC, 12'hFFF, 12'h456, 12'h789, 12'hDEF, 12'h800};
    vecs[12] = '{3'd7, 4'd15, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h800};
    rst_n = 1'b0;
    sel = 3'd0; vol = 4'd8;
    sin = '0; od = '0; dly = '0; ech = '0; rev = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {sync_n, sclk, din, tick, busy, overrun}, 6'b110000);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      sel = vecs[i].sel; vol = vecs[i].vol;
      sin = vecs[i].sin; od = vecs[i].od; dly = vecs[i].dly; ech = vecs[i].ech; rev = vecs[i].rev;
      capture(-1, 3'd0, f, low);
      chk($sformatf("frame_v%0d", i), f, {4'b0000, vecs[i].y});
      chk($sformatf("sync_low_v%0d", i), low, 128);
    end
    sel = 3'd0; vol = 4'd8; sin = 12'h111; od = 12'h222;
    capture(20, 3'd1, f, low);
    chk("midframe_sel_current", f, 16'h0111);
    capture(-1, 3'd0, f, low);
    chk("midframe_sel_next", f, 16'h0222);
    chk("no_overrun_min_period", overrun, 0);
    n = 0;
    while (!busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("busy_before_force", busy, 1);
    force dut.sample_tick = 1'b1;
    @(negedge clk);
    release dut.sample_tick;
    chk("overrun_set", overrun, 1);
    capture(-1, 3'd0, f, low);
    chk("frame_after_overrun", f, 16'h0222);
    chk("overrun_sticky", overrun, 1);
    sel = 3'd0; sin = 12'hFFF;
    wait_sync(1'b1, ok);
    if (ok) wait_sync(1'b0, ok);
    chk("reset_frame_start", ok, 1);
    prev = sclk;
    rises = 0;
    n = 0;
    while (rises < 7 && n < 400) begin
      @(negedge clk);
      n++;
      if (!prev && sclk) rises++;
      prev = sclk;
    end
    chk("sclk_rises_before_reset", rises, 7);
    chk("din_before_reset", din, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_abort", {sync_n, sclk, din, busy, tick, overrun}, 6'b110000);
    rst_n = 1'b1;
    n = 1;
    while (!tick && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("first_tick_after_reset", n, 132);
    capture(-1, 3'd0, f, low);
    chk("frame_after_reset", f, 16'h0FFF);
    chk("sync_low_after_reset", low, 128);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
